perf_counter_bank: RTL and testbench
====================================

Name: perf_counter_bank

Overview:
- Parametrised bank of NUM_CNT event counters; successor to the single free-running cycle counter exported by the CPU top.
- Channel 0 is always the cycle counter and also drives the `cycle` output, so existing benches that read `cycle` keep working.
- Channels 1..NUM_CNT-1 count core events (retired instr, loads, stores, branches taken), with preload, clear, snapshot, overflow flags and wrap/saturate mode.
- Sits beside the CPU core inside top; read by testbench and future CSR logic.

Parameters:
- NUM_CNT, 4, number of counters (2..16); channel 0 = cycles.
- CNT_W, 32, counter width in bits (8..64).
- SAT_MODE, 0, 0 = wrap to zero on overflow, 1 = hold at all-ones.
- IDX_W, clog2(NUM_CNT), index width (derived, not overridden).

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- en  in  1  global count enable.
- event  in  NUM_CNT  per-channel increment request; bit 0 ignored.
- clr  in  1  clear all counters, shadows and ovf.
- wr_en  in  1  preload strobe.
- wr_idx  in  IDX_W  preload target.
- wr_data  in  CNT_W  preload value.
- snap  in  1  copy all live counters to shadow registers.
- rd_idx  in  IDX_W  read select.
- rd_shadow  in  1  1 = read shadow copy, 0 = live counter.
- rd_data  out  CNT_W  registered read data.
- ovf  out  NUM_CNT  sticky overflow flags.
- cycle  out  CNT_W  live value of counter 0 (direct register output).

Behaviour:
- Reset (rst=0 at posedge) clears all counters, shadows, ovf and rd_data to 0. Reset overrides every other input, including mid-operation.
- Per-channel update priority each cycle: reset > wr_en (matching idx) > clr > increment.
- Increment condition:
  - ch0: en=1.
  - ch k>0: en=1 and event[k]=1.
  - At most +1 per cycle per channel.
- Overflow, increment attempted while counter = all-ones:
  - SAT_MODE=0: counter becomes 0 and ovf[k] is set.
  - SAT_MODE=1: counter stays all-ones and ovf[k] is set.
  - ovf[k] is sticky. It is cleared only by reset, clr, or a wr_en to channel k.
- Preload: wr_en writes wr_data to channel wr_idx at the edge. That channel's increment in the same cycle is dropped, and its ovf is cleared. Other channels count normally.
- wr_idx >= NUM_CNT: write ignored.
- clr with wr_en in the same cycle: the written channel takes wr_data; all other channels go to 0.
- Snapshot: snap=1 loads every shadow[k] with the live value before this edge's update (pre-increment).
  - clr+snap in the same cycle: shadows are cleared (clr wins).
- Read path:
  - Registered, 1-cycle latency: rd_data at edge t+1 = selected source sampled at edge t, using pre-update values.
  - rd_idx >= NUM_CNT returns 0.
  - A read and a write to the same index in the same cycle returns the old value.
- cycle = live counter 0 register. It is visible the cycle after each edge, with no extra latency.
- No FSM. Behaviour is per-channel counter/shadow/flag registers plus a registered read mux.

Decomposition:
- Shared package `perf_pkg` holds:
  - event index constants: EV_CYCLE=0, EV_INSTRET=1, EV_LOAD=2, EV_STORE=3, EV_BR_TAKEN=4;
  - SAT_MODE encodings;
  - the clog2 helper function.
- One natural sub-module, `perf_counter_chan`, instanced NUM_CNT times with a generate loop. It holds one counter, its shadow and its ovf bit, plus the increment/saturate/priority logic.
- The read mux and index decode stay in the top-level block.

Test Plan:
1. rst=0 for 5 cycles, then rst=1 with en=1 for 100 cycles → cycle=100, counters 1..3 = 0, ovf=0, rd_data=0 while in reset.
2. CNT_W=8, SAT_MODE=0: preload ch1=254, hold event[1]=1 for 3 cycles → values 255, 0, 1; ovf[1]=1 and stays 1 after event drops. Repeat with SAT_MODE=1 → holds 255, ovf[1]=1.
3. event[2]=1 continuously; wr_en to idx 2 with wr_data=0x10 in the same cycle → next value 0x10 (not 0x11), then 0x11. ovf[2] clears.
4. ch0=500 live; pulse snap, run 20 more cycles, then rd_idx=0 with rd_shadow=1 → rd_data=500 one cycle later. With rd_shadow=0 → rd_data equals the live value from the previous edge.
5. clr and wr_en(idx 3, 0x55) together, with ovf pre-set → ch3=0x55, all other channels 0, all shadows 0, ovf=0. Then rd_idx=NUM_CNT → rd_data=0.
6. Assert rst=0 mid-count with snap and wr_en active → all registers 0 at that edge. Counting resumes from 0 on the first en cycle after release.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared constants for the performance counter bank: event channel map,
// overflow-mode encodings and the index-width helper.
package perf_pkg;

   localparam int EV_CYCLE    = 0;
   localparam int EV_INSTRET  = 1;
   localparam int EV_LOAD     = 2;
   localparam int EV_STORE    = 3;
   localparam int EV_BR_TAKEN = 4;

   localparam int SAT_WRAP = 0;
   localparam int SAT_HOLD = 1;

   // Ceiling log2 with a floor of 1 so a select port is never zero bits wide.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/perf_counter_chan.sv
// One event counter channel: live counter, snapshot shadow and sticky
// overflow flag, with preload > clear > increment priority.
module perf_counter_chan
   import perf_pkg::*;
#(
   parameter int CNT_W    = 32,
   parameter int SAT_MODE = SAT_WRAP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   input  logic             i_wr,
   input  logic [CNT_W-1:0] i_wr_data,
   input  logic             i_clr,
   input  logic             i_snap,
   output logic [CNT_W-1:0] o_cnt,
   output logic [CNT_W-1:0] o_shadow,
   output logic             o_ovf
);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_shadow;
   logic             r_ovf;
   logic             w_at_max;

   assign w_at_max = &r_cnt;

   // NOTE: state updates use <= so every register samples pre-edge values;
   // that is what makes the snapshot capture the pre-increment count.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt    <= '0;
         // NOTE: the shadow is a plain register that readers may see, so it
         // is reset too rather than left as unknown storage.
         r_shadow <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (i_wr) begin
            r_cnt <= i_wr_data;
            r_ovf <= 1'b0;
         end else if (i_clr) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
         end else if (i_inc) begin
            if (w_at_max) begin
               r_cnt <= (SAT_MODE == SAT_HOLD) ? r_cnt : '0;
               r_ovf <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end

         if (i_clr) begin
            r_shadow <= '0;
         end else if (i_snap) begin
            r_shadow <= r_cnt;
         end
      end
   end

   assign o_cnt    = r_cnt;
   assign o_shadow = r_shadow;
   assign o_ovf    = r_ovf;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CNT event counters; channel 0 counts cycles and doubles as the
// legacy cycle output. Registered read mux over live or shadow copies.
module perf_counter_bank
   import perf_pkg::*;
#(
   parameter  int NUM_CNT  = 4,
   parameter  int CNT_W    = 32,
   parameter  int SAT_MODE = SAT_WRAP,
   localparam int IDX_W    = clog2(NUM_CNT)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_en,
   input  logic [NUM_CNT-1:0] i_event,
   input  logic               i_clr,
   input  logic               i_wr_en,
   input  logic [IDX_W-1:0]   i_wr_idx,
   input  logic [CNT_W-1:0]   i_wr_data,
   input  logic               i_snap,
   input  logic [IDX_W-1:0]   i_rd_idx,
   input  logic               i_rd_shadow,
   output logic [CNT_W-1:0]   o_rd_data,
   output logic [NUM_CNT-1:0] o_ovf,
   output logic [CNT_W-1:0]   o_cycle
);

   logic [CNT_W-1:0] w_cnt    [NUM_CNT];
   logic [CNT_W-1:0] w_shadow [NUM_CNT];
   logic [CNT_W-1:0] w_rd_sel;
   logic [CNT_W-1:0] r_rd_data;
   logic             w_unused_event0;

   // The cycle channel ignores its event bit.
   assign w_unused_event0 = i_event[EV_CYCLE];

   for (genvar k = 0; k < NUM_CNT; k++) begin : g_chan
      logic w_inc;
      logic w_wr;

      if (k == EV_CYCLE) begin : g_cycle
         assign w_inc = i_en;
      end else begin : g_event
         assign w_inc = i_en & i_event[k];
      end

      assign w_wr = i_wr_en && (i_wr_idx == IDX_W'(k));

      perf_counter_chan #(
         .CNT_W    (CNT_W),
         .SAT_MODE (SAT_MODE)
      ) u_chan (
         .clk       (clk),
         .rst       (rst),
         .i_inc     (w_inc),
         .i_wr      (w_wr),
         .i_wr_data (i_wr_data),
         .i_clr     (i_clr),
         .i_snap    (i_snap),
         .o_cnt     (w_cnt[k]),
         .o_shadow  (w_shadow[k]),
         .o_ovf     (o_ovf[k])
      );
   end

   always_comb begin
      // NOTE: default first so an out-of-range index yields 0 and no latch forms.
      w_rd_sel = '0;
      for (int k = 0; k < NUM_CNT; k++) begin
         if (i_rd_idx == IDX_W'(k)) begin
            w_rd_sel = i_rd_shadow ? w_shadow[k] : w_cnt[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rd_data <= '0;
      end else begin
         r_rd_data <= w_rd_sel;
      end
   end

   assign o_rd_data = r_rd_data;
   assign o_cycle   = w_cnt[EV_CYCLE];

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench: a 5-channel 16-bit wrapping bank for most features plus two
// 4-channel 8-bit banks (wrap and saturate) sharing the same stimulus.
module tb_perf_counter_bank;

   logic        clk;
   logic        rst;
   logic        en;
   logic [4:0]  ev;
   logic        clr;
   logic        wr_en;
   logic [2:0]  wr_idx;
   logic [15:0] wr_data;
   logic        snap;
   logic [2:0]  rd_idx;
   logic        rd_shadow;

   logic [15:0] rd_a, cyc_a;
   logic [4:0]  ovf_a;
   logic [7:0]  rd_w, cyc_w, rd_s, cyc_s;
   logic [3:0]  ovf_w, ovf_s;

   int errors = 0;
   int checks = 0;

   perf_counter_bank #(.NUM_CNT(5), .CNT_W(16), .SAT_MODE(0)) dut_a (
      .clk(clk), .rst(rst), .i_en(en), .i_event(ev), .i_clr(clr),
      .i_wr_en(wr_en), .i_wr_idx(wr_idx), .i_wr_data(wr_data), .i_snap(snap),
      .i_rd_idx(rd_idx), .i_rd_shadow(rd_shadow),
      .o_rd_data(rd_a), .o_ovf(ovf_a), .o_cycle(cyc_a)
   );

   perf_counter_bank #(.NUM_CNT(4), .CNT_W(8), .SAT_MODE(0)) dut_w (
      .clk(clk), .rst(rst), .i_en(en), .i_event(ev[3:0]), .i_clr(clr),
      .i_wr_en(wr_en), .i_wr_idx(wr_idx[1:0]), .i_wr_data(wr_data[7:0]), .i_snap(snap),
      .i_rd_idx(rd_idx[1:0]), .i_rd_shadow(rd_shadow),
      .o_rd_data(rd_w), .o_ovf(ovf_w), .o_cycle(cyc_w)
   );

   perf_counter_bank #(.NUM_CNT(4), .CNT_W(8), .SAT_MODE(1)) dut_s (
      .clk(clk), .rst(rst), .i_en(en), .i_event(ev[3:0]), .i_clr(clr),
      .i_wr_en(wr_en), .i_wr_idx(wr_idx[1:0]), .i_wr_data(wr_data[7:0]), .i_snap(snap),
      .i_rd_idx(rd_idx[1:0]), .i_rd_shadow(rd_shadow),
      .o_rd_data(rd_s), .o_ovf(ovf_s), .o_cycle(cyc_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      en = 1'b0; ev = '0; clr = 1'b0; wr_en = 1'b0; wr_idx = '0;
      wr_data = '0; snap = 1'b0; rd_idx = '0; rd_shadow = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b0;
      en  = 1'b1;
      repeat (5) tick();
      checks++; if (cyc_a !== 16'd0) begin errors++; $display("FAIL reset_cycle: got %0d expected 0", cyc_a); end
      checks++; if (ovf_a !== 5'd0) begin errors++; $display("FAIL reset_ovf: got %b expected 00000", ovf_a); end
      checks++; if (rd_a !== 16'd0) begin errors++; $display("FAIL reset_rd_data: got %0h expected 0", rd_a); end
      rst = 1'b1;
      repeat (100) tick();
      checks++; if (cyc_a !== 16'd100) begin errors++; $display("FAIL cycle_100: got %0d expected 100", cyc_a); end
      checks++; if (cyc_w !== 8'd100) begin errors++; $display("FAIL cycle_100_w8: got %0d expected 100", cyc_w); end
      en = 1'b0;
      for (int k = 1; k < 5; k++) begin
         rd_idx = 3'(k);
         tick();
         checks++; if (rd_a !== 16'd0) begin errors++; $display("FAIL idle_chan%0d: got %0h expected 0", k, rd_a); end
      end
      checks++; if (cyc_a !== 16'd100) begin errors++; $display("FAIL cycle_hold: got %0d expected 100", cyc_a); end
      checks++; if (ovf_a !== 5'd0) begin errors++; $display("FAIL ovf_after_count: got %b expected 00000", ovf_a); end
   endtask

   task automatic test_overflow();
      logic [7:0] exp_w [4];
      logic [7:0] exp_s [4];
      exp_w = '{8'd254, 8'd255, 8'd0, 8'd1};
      exp_s = '{8'd254, 8'd255, 8'd255, 8'd255};
      idle_inputs();
      wr_en = 1'b1; wr_idx = 3'd1; wr_data = 16'd254;
      tick();
      wr_en = 1'b0; en = 1'b1; ev = 5'b00010; rd_idx = 3'd1;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) ev = '0;
         tick();
         checks++; if (rd_w !== exp_w[i]) begin errors++; $display("FAIL wrap_seq%0d: got %0d expected %0d", i, rd_w, exp_w[i]); end
         checks++; if (rd_s !== exp_s[i]) begin errors++; $display("FAIL sat_seq%0d: got %0d expected %0d", i, rd_s, exp_s[i]); end
         if (i == 0) begin
            checks++; if (ovf_w[1] !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", ovf_w[1]); end
         end
      end
      tick();
      checks++; if (ovf_w[1] !== 1'b1) begin errors++; $display("FAIL wrap_ovf_sticky: got %b expected 1", ovf_w[1]); end
      checks++; if (ovf_s[1] !== 1'b1) begin errors++; $display("FAIL sat_ovf_sticky: got %b expected 1", ovf_s[1]); end
      checks++; if (rd_s !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d expected 255", rd_s); end
      checks++; if (ovf_a[1] !== 1'b0) begin errors++; $display("FAIL wide_no_ovf: got %b expected 0", ovf_a[1]); end
      en = 1'b0;
   endtask

   task automatic test_preload_vs_event();
      idle_inputs();
      en = 1'b1; ev = 5'b00100;
      wr_en = 1'b1; wr_idx = 3'd2; wr_data = 16'hFFFF;
      tick();
      wr_en = 1'b0;
      tick();
      checks++; if (ovf_a[2] !== 1'b1) begin errors++; $display("FAIL pre_ovf2: got %b expected 1", ovf_a[2]); end
      wr_en = 1'b1; wr_data = 16'h0010; rd_idx = 3'd2; rd_shadow = 1'b0;
      tick();
      checks++; if (rd_a !== 16'h0000) begin errors++; $display("FAIL rd_old_on_write: got %0h expected 0", rd_a); end
      checks++; if (ovf_a[2] !== 1'b0) begin errors++; $display("FAIL ovf2_cleared: got %b expected 0", ovf_a[2]); end
      wr_en = 1'b0;
      tick();
      checks++; if (rd_a !== 16'h0010) begin errors++; $display("FAIL preload_drop_inc: got %0h expected 10", rd_a); end
      tick();
      checks++; if (rd_a !== 16'h0011) begin errors++; $display("FAIL preload_then_inc: got %0h expected 11", rd_a); end
      en = 1'b0; ev = '0;
   endtask

   task automatic test_snapshot();
      idle_inputs();
      wr_en = 1'b1; wr_idx = 3'd0; wr_data = 16'd500;
      tick();
      wr_en = 1'b0; en = 1'b1; snap = 1'b1;
      tick();
      snap = 1'b0;
      repeat (20) tick();
      rd_idx = 3'd0; rd_shadow = 1'b1;
      tick();
      checks++; if (rd_a !== 16'd500) begin errors++; $display("FAIL snap_shadow: got %0d expected 500", rd_a); end
      checks++; if (cyc_a !== 16'd522) begin errors++; $display("FAIL snap_live_cycle: got %0d expected 522", cyc_a); end
      rd_shadow = 1'b0;
      tick();
      checks++; if (rd_a !== 16'd522) begin errors++; $display("FAIL live_read: got %0d expected 522", rd_a); end
      checks++; if (cyc_a !== 16'd523) begin errors++; $display("FAIL live_cycle: got %0d expected 523", cyc_a); end
      en = 1'b0;
   endtask

   task automatic test_clr_with_write();
      idle_inputs();
      wr_en = 1'b1; wr_idx = 3'd4; wr_data = 16'hFFFF;
      tick();
      wr_en = 1'b0; en = 1'b1; ev = 5'b10000;
      tick();
      checks++; if (ovf_a !== 5'b10000) begin errors++; $display("FAIL ovf_preset: got %b expected 10000", ovf_a); end
      en = 1'b0; ev = '0; snap = 1'b1;
      tick();
      en = 1'b1; ev = 5'b11111; clr = 1'b1;
      wr_en = 1'b1; wr_idx = 3'd3; wr_data = 16'h0055;
      tick();
      idle_inputs();
      checks++; if (ovf_a !== 5'd0) begin errors++; $display("FAIL clr_ovf: got %b expected 00000", ovf_a); end
      checks++; if (cyc_a !== 16'd0) begin errors++; $display("FAIL clr_cycle: got %0d expected 0", cyc_a); end
      for (int k = 0; k < 5; k++) begin
         rd_idx = 3'(k); rd_shadow = 1'b1;
         tick();
         checks++; if (rd_a !== 16'd0) begin errors++; $display("FAIL clr_shadow%0d: got %0h expected 0", k, rd_a); end
      end
      for (int k = 0; k < 5; k++) begin
         rd_idx = 3'(k); rd_shadow = 1'b0;
         tick();
         checks++; if (rd_a !== ((k == 3) ? 16'h0055 : 16'h0000)) begin
            errors++; $display("FAIL clr_live%0d: got %0h expected %0h", k, rd_a, (k == 3) ? 16'h0055 : 16'h0000);
         end
      end
      rd_idx = 3'd3;
      tick();
      checks++; if (rd_a !== 16'h0055) begin errors++; $display("FAIL reread_ch3: got %0h expected 55", rd_a); end
      rd_idx = 3'd5;
      tick();
      checks++; if (rd_a !== 16'd0) begin errors++; $display("FAIL rd_oob5: got %0h expected 0", rd_a); end
      rd_idx = 3'd3;
      tick();
      rd_idx = 3'd7; rd_shadow = 1'b1;
      tick();
      checks++; if (rd_a !== 16'd0) begin errors++; $display("FAIL rd_oob7: got %0h expected 0", rd_a); end
   endtask

   task automatic test_mid_reset();
      idle_inputs();
      en = 1'b1; ev = 5'b00110;
      wr_en = 1'b1; wr_idx = 3'd2; wr_data = 16'hFFFF;
      tick();
      wr_en = 1'b0;
      repeat (3) tick();
      rst = 1'b0; snap = 1'b1; wr_en = 1'b1; wr_idx = 3'd1; wr_data = 16'h00AA;
      rd_idx = 3'd0;
      tick();
      checks++; if (cyc_a !== 16'd0) begin errors++; $display("FAIL mid_rst_cycle: got %0d expected 0", cyc_a); end
      checks++; if (ovf_a !== 5'd0) begin errors++; $display("FAIL mid_rst_ovf: got %b expected 00000", ovf_a); end
      checks++; if (ovf_w !== 4'd0) begin errors++; $display("FAIL mid_rst_ovf_w8: got %b expected 0000", ovf_w); end
      checks++; if (rd_a !== 16'd0) begin errors++; $display("FAIL mid_rst_rd: got %0h expected 0", rd_a); end
      rst = 1'b1; en = 1'b0; snap = 1'b0; wr_en = 1'b0; rd_idx = 3'd1;
      tick();
      checks++; if (rd_a !== 16'd0) begin errors++; $display("FAIL rst_beat_write: got %0h expected 0", rd_a); end
      checks++; if (cyc_a !== 16'd0) begin errors++; $display("FAIL rst_idle_cycle: got %0d expected 0", cyc_a); end
      en = 1'b1;
      tick();
      checks++; if (cyc_a !== 16'd1) begin errors++; $display("FAIL resume_cycle1: got %0d expected 1", cyc_a); end
      tick();
      checks++; if (cyc_a !== 16'd2) begin errors++; $display("FAIL resume_cycle2: got %0d expected 2", cyc_a); end
      checks++; if (rd_a !== 16'd1) begin errors++; $display("FAIL resume_ch1: got %0d expected 1", rd_a); end
      en = 1'b0; rd_idx = 3'd2; rd_shadow = 1'b1;
      tick();
      checks++; if (rd_a !== 16'd0) begin errors++; $display("FAIL rst_beat_snap: got %0h expected 0", rd_a); end
   endtask

   initial begin
      rst = 1'b0;
      idle_inputs();
      test_reset();
      test_overflow();
      test_preload_vs_event();
      test_snapshot();
      test_clr_with_write();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
